// File: rtl/pcie_pkg.sv
// pcie_pkg
// Shared types and default timing for the PCIe endpoint reset sequencer.
//   pcie_rst_state_t : sequencer state encoding (also driven out on the debug
//                      'state' port of pcie_perst_sequencer)
//   DEF_*            : default cycle counts used as parameter defaults
//   max_of4          : helper that sizes the shared down-counter
package pcie_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    HOLD      = 3'd1,
    PHY_WAIT  = 3'd2,
    CORE_WAIT = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pcie_rst_state_t;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_HOLD_CYCLES       = 100;
  localparam int DEF_CORE_DELAY_CYCLES = 32;
  localparam int DEF_TIMEOUT_CYCLES    = 4096;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pcie_perst_filter.sv
// pcie_perst_filter
// Synchronizes the root's asynchronous PERST# and debounces its release.
// Assertion (low) passes straight through the synchronizer with no filtering;
// deassertion is accepted only after DEBOUNCE_CYCLES consecutive high samples.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (filter comes up "PERST asserted")
//   perst_n    : raw PERST#, asynchronous to clk
//   perst_f    : filtered PERST# (registered)
//   perst_fall : one-cycle pulse on each 1->0 transition of perst_f
module pcie_perst_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic perst_n,
  output logic perst_f,
  output logic perst_fall
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   perst_f_q, perst_f_d;
  logic                   perst_f_dly_q;
  logic                   perst_s;

  assign perst_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      db_cnt_q      <= '0;
      perst_f_q     <= 1'b0;
      perst_f_dly_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], perst_n};
      db_cnt_q      <= db_cnt_d;
      perst_f_q     <= perst_f_d;
      perst_f_dly_q <= perst_f_q;
    end
  end

  // Any low sample drops perst_f immediately and restarts the run of highs.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    perst_f_d = perst_f_q;
    if (!perst_s) begin
      db_cnt_d  = '0;
      perst_f_d = 1'b0;
    end else if (!perst_f_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        perst_f_d = 1'b1;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign perst_f    = perst_f_q;
  assign perst_fall = perst_f_dly_q & ~perst_f_q;

endmodule

// File: rtl/pcie_perst_sequencer.sv
// pcie_perst_sequencer
// Endpoint-side reset sequencer: filters PERST#, then releases PHY reset and
// later core reset in a timed order, flags a PHY-ready timeout and counts
// accepted PERST assertions.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   perst_n       : root PERST#, asynchronous
//   refclk_locked : refclk PLL lock (clk domain)
//   phy_ready     : PHY reset-done (clk domain)
//   phy_rst_n     : PHY reset, active-low
//   core_rst_n    : controller/user reset, active-low
//   link_en       : permits link training
//   fault         : PHY-ready timeout flag
//   state         : current pcie_rst_state_t encoding
//   perst_events  : saturating count of perst_f falling edges
module pcie_perst_sequencer
  import pcie_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
  parameter int CORE_DELAY_CYCLES = DEF_CORE_DELAY_CYCLES,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        perst_n,
  input  logic        refclk_locked,
  input  logic        phy_ready,
  output logic        phy_rst_n,
  output logic        core_rst_n,
  output logic        link_en,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] perst_events
);

  localparam int MAX_CYC = max_of4(DEBOUNCE_CYCLES, HOLD_CYCLES, CORE_DELAY_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  logic perst_f, perst_fall;

  pcie_perst_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .perst_n   (perst_n),
    .perst_f   (perst_f),
    .perst_fall(perst_fall)
  );

  pcie_rst_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy_rst_n_q, core_rst_n_q, link_en_q, fault_q;
  logic [15:0]      perst_events_q;
  logic             cnt_zero, abort;

  assign cnt_zero = (cnt_q == '0);
  assign abort    = !perst_f || !refclk_locked;

  // Next state. Abort outranks every other transition, including counter
  // expiry; FAULT is sticky until a fresh PERST assertion is seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != FAULT && abort) begin
      state_d = RESET;
    end else begin
      case (state_q)
        RESET: begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES);
        end
        HOLD: begin
          if (cnt_zero) begin
            state_d = PHY_WAIT;
            cnt_d   = CNT_W'(TIMEOUT_CYCLES);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        PHY_WAIT: begin
          if (phy_ready) begin
            state_d = CORE_WAIT;
            cnt_d   = CNT_W'(CORE_DELAY_CYCLES);
          end else if (cnt_zero) begin
            state_d = FAULT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CORE_WAIT: begin
          if (!phy_ready) begin
            state_d = RESET;
          end else if (cnt_zero) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        FAULT: begin
          if (perst_fall) state_d = RESET;
        end
        default: begin
          state_d = RESET;
        end
      endcase
    end
  end

  // Outputs are decoded from state_d into flops so they change on the same
  // edge as state_q and never see an input combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET;
      cnt_q        <= '0;
      phy_rst_n_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      link_en_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phy_rst_n_q  <= (state_d == PHY_WAIT) || (state_d == CORE_WAIT) || (state_d == RUN);
      core_rst_n_q <= (state_d == RUN);
      link_en_q    <= (state_d == RUN);
      fault_q      <= (state_d == FAULT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_events_q <= '0;
    end else if (perst_fall && perst_events_q != 16'hFFFF) begin
      perst_events_q <= perst_events_q + 16'd1;
    end
  end

  assign phy_rst_n    = phy_rst_n_q;
  assign core_rst_n   = core_rst_n_q;
  assign link_en      = link_en_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign perst_events = perst_events_q;

endmodule
